// File: rtl/vehicle_detect_cond.sv
// Two-direction loop-sensor conditioner: synchronize, debounce, and latch service requests.
// Optional macro VEH_WAIT_COUNT_EN adds saturating per-direction pending-wait counters.
module vehicle_detect_cond #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_NS_raw,
    input  logic       i_EW_raw,
    input  logic       i_NS_served,
    input  logic       i_EW_served,
    output logic       NS_vehicle_detect,
    output logic       EW_vehicle_detect,
    output logic       o_NS_req,
    output logic       o_EW_req,
    output logic [4:0] o_NS_wait,
    output logic [4:0] o_EW_wait
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUAL_ON  = 2'd1,
        ACTIVE   = 2'd2,
        QUAL_OFF = 2'd3
    } qual_state_t;

    localparam logic [3:0] DEB = 4'(DEBOUNCE_CYCLES);

    logic [1:0]      raw;
    logic [1:0]      served;
    logic [1:0]      detect;
    logic [1:0]      req;
    logic [1:0][4:0] wait_cnt;

    // Index 0 is north-south, index 1 is east-west.
    assign raw    = {i_EW_raw, i_NS_raw};
    assign served = {i_EW_served, i_NS_served};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dir
            logic        sync1_reg;
            logic        sync2_reg;
            qual_state_t state_reg;
            qual_state_t state_next;
            logic [3:0]  cnt_reg;
            logic [3:0]  cnt_next;
            logic        detect_prev_reg;
            logic        req_reg;
            logic        req_set;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    state_reg <= IDLE;
                    cnt_reg   <= 4'd0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // The counter holds how many consecutive samples have disagreed with the current level.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    IDLE: begin
                        if (sync2_reg) begin
                            if (DEB <= 4'd1) begin
                                state_next = ACTIVE;
                                cnt_next   = 4'd0;
                            end else begin
                                state_next = QUAL_ON;
                                cnt_next   = 4'd1;
                            end
                        end
                    end
                    QUAL_ON: begin
                        if (!sync2_reg) begin
                            state_next = IDLE;
                            cnt_next   = 4'd0;
                        end else if ((cnt_reg + 4'd1) >= DEB) begin
                            state_next = ACTIVE;
                            cnt_next   = 4'd0;
                        end else begin
                            cnt_next = cnt_reg + 4'd1;
                        end
                    end
                    ACTIVE: begin
                        if (!sync2_reg) begin
                            if (DEB <= 4'd1) begin
                                state_next = IDLE;
                                cnt_next   = 4'd0;
                            end else begin
                                state_next = QUAL_OFF;
                                cnt_next   = 4'd1;
                            end
                        end
                    end
                    QUAL_OFF: begin
                        if (sync2_reg) begin
                            state_next = ACTIVE;
                            cnt_next   = 4'd0;
                        end else if ((cnt_reg + 4'd1) >= DEB) begin
                            state_next = IDLE;
                            cnt_next   = 4'd0;
                        end else begin
                            cnt_next = cnt_reg + 4'd1;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = 4'd0;
                    end
                endcase
            end

            assign detect[gi] = (state_reg == ACTIVE) || (state_reg == QUAL_OFF);
            assign req_set    = detect[gi] & ~detect_prev_reg;

            // Set wins over served; a falling detect never clears a pending request.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    detect_prev_reg <= 1'b0;
                    req_reg         <= 1'b0;
                end else begin
                    detect_prev_reg <= detect[gi];
                    if (req_set) begin
                        req_reg <= 1'b1;
                    end else if (served[gi]) begin
                        req_reg <= 1'b0;
                    end
                end
            end

            assign req[gi] = req_reg;

`ifdef VEH_WAIT_COUNT_EN
            logic [4:0] wait_reg;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    wait_reg <= 5'd0;
                end else if (req_set || !req_reg || served[gi]) begin
                    wait_reg <= 5'd0;
                end else if (wait_reg != 5'd31) begin
                    wait_reg <= wait_reg + 5'd1;
                end
            end

            assign wait_cnt[gi] = wait_reg;
`else
            assign wait_cnt[gi] = 5'd0;
`endif
        end
    endgenerate

    assign NS_vehicle_detect = detect[0];
    assign EW_vehicle_detect = detect[1];
    assign o_NS_req          = req[0];
    assign o_EW_req          = req[1];
    assign o_NS_wait         = wait_cnt[0];
    assign o_EW_wait         = wait_cnt[1];

endmodule
